// File: rtl/crc_pkg.sv
// Shared types and defaults for the serial CRC engine family.
// Ports: none (package).
package crc_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      OUT
   } crc_state_t;

   localparam logic MODE_GEN   = 1'b0;
   localparam logic MODE_CHECK = 1'b1;

   localparam logic [7:0] CRC8_TAPS = 8'h44;
   localparam logic [7:0] CRC8_SEED = 8'hD8;

endpackage

// File: rtl/crc_lfsr_step.sv
// One-bit step of a right-shifting Galois LFSR, LSB-first input.
// Ports: lfsr (current value), din (serial bit), nxt (next value).
module crc_lfsr_step
   import crc_pkg::*;
#(
   parameter int               CRC_W = 8,
   parameter logic [CRC_W-1:0] TAPS  = CRC_W'(CRC8_TAPS)
)(
   input  logic [CRC_W-1:0] lfsr,
   input  logic             din,
   output logic [CRC_W-1:0] nxt
);

   logic fb;

   assign fb = din ^ lfsr[0];

   // TAPS[CRC_W-1] has no slot: the MSB always takes the feedback.
   always_comb begin
      nxt = '0;
      nxt[CRC_W-1] = fb;
      for (int i = 0; i < CRC_W-1; i++) begin
         nxt[i] = lfsr[i+1] ^ (TAPS[i] & fb);
      end
   end

endmodule

// File: rtl/crc_serial_engine.sv
// Serial CRC engine: accumulate, then shift out (GEN) or compare (CHECK).
// Ports: CLK, RST, Clear, Data, Active, Mode in; Valid, CRC, Busy, Check_Done, Check_Err out.
module crc_serial_engine
   import crc_pkg::*;
#(
   parameter int               CRC_W   = 8,
   parameter logic [CRC_W-1:0] TAPS    = CRC_W'(CRC8_TAPS),
   parameter logic [CRC_W-1:0] SEED    = CRC_W'(CRC8_SEED),
   parameter logic [CRC_W-1:0] XOR_OUT = '0
)(
   input  logic CLK,
   input  logic RST,
   input  logic Clear,
   input  logic Data,
   input  logic Active,
   input  logic Mode,
   output logic Valid,
   output logic CRC,
   output logic Busy,
   output logic Check_Done,
   output logic Check_Err
);

   localparam int              CNT_W = $clog2(CRC_W);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(CRC_W-1);

   crc_state_t       state, state_n;
   logic [CRC_W-1:0] lfsr, lfsr_n, step, fin;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic             mode, mode_n;
   logic             err_acc, err_n;
   logic             valid_n, crc_n, done_n, cerr_n;
   logic             obit, miss, emit, last;

   crc_lfsr_step #(
      .CRC_W (CRC_W),
      .TAPS  (TAPS)
   ) u_step (
      .lfsr (lfsr),
      .din  (Data),
      .nxt  (step)
   );

   assign Busy = (state == OUT);

   // Bit 0 leaves straight from the finalised value on the entry edge;
   // later bits come from the already-finalised, shifting register.
   assign fin  = lfsr ^ XOR_OUT;
   assign obit = (state == OUT) ? lfsr[0] : fin[0];
   assign miss = Data != obit;

   always_comb begin
      state_n = state;
      lfsr_n  = lfsr;
      cnt_n   = cnt;
      mode_n  = mode;
      err_n   = err_acc;
      valid_n = 1'b0;
      crc_n   = 1'b0;
      done_n  = 1'b0;
      cerr_n  = Check_Err;
      emit    = 1'b0;
      last    = 1'b0;
      if (Clear) begin
         state_n = IDLE;
         lfsr_n  = SEED;
         cnt_n   = '0;
         err_n   = 1'b0;
         cerr_n  = 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (Active) begin
                  lfsr_n  = step;
                  mode_n  = Mode;
                  err_n   = 1'b0;
                  cerr_n  = 1'b0;
                  state_n = ACCUM;
               end
            end
            ACCUM: begin
               if (Active) begin
                  lfsr_n = step;
               end else begin
                  lfsr_n  = fin >> 1;
                  cnt_n   = CNT_W'(1);
                  emit    = 1'b1;
                  state_n = OUT;
               end
            end
            OUT: begin
               lfsr_n = lfsr >> 1;
               cnt_n  = cnt + CNT_W'(1);
               emit   = 1'b1;
               if (cnt == LAST) begin
                  last    = 1'b1;
                  lfsr_n  = SEED;
                  cnt_n   = '0;
                  state_n = IDLE;
               end
            end
            default: state_n = IDLE;
         endcase
         if (emit) begin
            if (mode == MODE_GEN) begin
               valid_n = 1'b1;
               crc_n   = obit;
            end else begin
               err_n = err_acc | miss;
            end
         end
         if (last && mode == MODE_CHECK) begin
            done_n = 1'b1;
            cerr_n = err_acc | miss;
         end
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state      <= IDLE;
         lfsr       <= SEED;
         cnt        <= '0;
         mode       <= MODE_GEN;
         err_acc    <= 1'b0;
         Valid      <= 1'b0;
         CRC        <= 1'b0;
         Check_Done <= 1'b0;
         Check_Err  <= 1'b0;
      end else begin
         state      <= state_n;
         lfsr       <= lfsr_n;
         cnt        <= cnt_n;
         mode       <= mode_n;
         err_acc    <= err_n;
         Valid      <= valid_n;
         CRC        <= crc_n;
         Check_Done <= done_n;
         Check_Err  <= cerr_n;
      end
   end

endmodule

// File: tb/tb_crc_serial_engine.sv
// Bench for crc_serial_engine: CRC-8 default and CRC-16 instances,
// frame-level reference model with per-cycle output expectations.
module tb_crc_serial_engine;
   import crc_pkg::*;

   typedef struct packed {
      logic v;
      logic c;
      logic b;
      logic d;
      logic e;
   } ex_t;
   typedef ex_t [1:0] exp2_t;
   typedef logic bq_t[$];

   logic CLK = 1'b0;
   always #5 CLK = ~CLK;

   logic rst[2];
   logic clr[2];
   logic dat[2];
   logic act[2];
   logic mod[2];
   logic vld[2];
   logic crc[2];
   logic bsy[2];
   logic cdn[2];
   logic cer[2];

   int          wid[2]  = '{8, 16};
   logic [31:0] taps[2] = '{32'h44, 32'h0408};
   logic [31:0] seed[2] = '{32'hD8, 32'hFFFF};
   logic [31:0] xo[2]   = '{32'h0, 32'hFFFF};

   int       total = 0;
   int       bad = 0;
   logic     m_err[2];
   logic [7:0] cap8 = '0;
   exp2_t    expq[$];

   crc_serial_engine u8 (
      .CLK(CLK), .RST(rst[0]), .Clear(clr[0]), .Data(dat[0]),
      .Active(act[0]), .Mode(mod[0]), .Valid(vld[0]), .CRC(crc[0]),
      .Busy(bsy[0]), .Check_Done(cdn[0]), .Check_Err(cer[0])
   );

   crc_serial_engine #(
      .CRC_W(16), .TAPS(16'h0408), .SEED(16'hFFFF), .XOR_OUT(16'hFFFF)
   ) u16 (
      .CLK(CLK), .RST(rst[1]), .Clear(clr[1]), .Data(dat[1]),
      .Active(act[1]), .Mode(mod[1]), .Valid(vld[1]), .CRC(crc[1]),
      .Busy(bsy[1]), .Check_Done(cdn[1]), .Check_Err(cer[1])
   );

   task automatic chk(string nm, int u, logic a, logic e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s[%0d] got=%b want=%b t=%0t", nm, u, a, e, $time);
      end
   endtask

   // Reflected CRC as polynomial division: XOR the full polynomial
   // (implicit top term at bit W-1) whenever the feedback bit is set.
   function automatic logic [31:0] crc_ref(int u, bq_t msg);
      logic [31:0] r;
      logic [31:0] top;
      logic [31:0] poly;
      r = seed[u];
      top = 32'h1 << (wid[u] - 1);
      poly = (taps[u] & ~top) | top;
      foreach (msg[i]) begin
         if (msg[i] ^ r[0]) r = (r >> 1) ^ poly;
         else r = r >> 1;
      end
      return r;
   endfunction

   function automatic bq_t mkq(logic [63:0] v, int n);
      bq_t q;
      for (int i = 0; i < n; i++) q.push_back(v[i]);
      return q;
   endfunction

   function automatic ex_t mk(logic v, logic c, logic b, logic d, logic e);
      ex_t x;
      x.v = v; x.c = c; x.b = b; x.d = d; x.e = e;
      return x;
   endfunction

   always @(negedge CLK) begin : cmp
      exp2_t x;
      if (vld[0] === 1'b1) cap8 = {crc[0], cap8[7:1]};
      if (expq.size() > 0) begin
         x = expq.pop_front();
         for (int u = 0; u < 2; u++) begin
            chk("valid", u, vld[u], x[u].v);
            chk("crc", u, crc[u], x[u].c);
            chk("busy", u, bsy[u], x[u].b);
            chk("done", u, cdn[u], x[u].d);
            chk("err", u, cer[u], x[u].e);
         end
      end
   end

   // Starts and ends at a falling edge; the unit not under test idles.
   task automatic step(int u, logic c, logic a, logic d, logic m, ex_t e);
      exp2_t x;
      for (int k = 0; k < 2; k++) begin
         clr[k] = 1'b0;
         act[k] = 1'b0;
         dat[k] = 1'($urandom);
         mod[k] = 1'($urandom);
         x[k] = mk(1'b0, 1'b0, 1'b0, 1'b0, m_err[k]);
      end
      clr[u] = c;
      act[u] = a;
      dat[u] = d;
      mod[u] = m;
      x[u] = e;
      @(posedge CLK);
      expq.push_back(x);
      @(negedge CLK);
   endtask

   task automatic idle(int u);
      step(u, 1'b0, 1'b0, 1'($urandom), 1'($urandom),
           mk(1'b0, 1'b0, 1'b0, 1'b0, m_err[u]));
   endtask

   task automatic run_frame(int u, logic m, bq_t msg, bq_t rx,
                            int clr_at, int pulse_at, int rst_at);
      logic [31:0] f;
      logic mis;
      logic g;
      logic d;
      logic lst;
      f = crc_ref(u, msg) ^ xo[u];
      g = (m == MODE_GEN);
      mis = 1'b0;
      m_err[u] = 1'b0;
      foreach (msg[i]) begin
         step(u, 1'b0, 1'b1, msg[i], (i == 0) ? m : 1'($urandom),
              mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      end
      for (int j = 0; j < wid[u]; j++) begin
         d = m ? rx[j] : 1'($urandom);
         if (j == clr_at) begin
            m_err[u] = 1'b0;
            step(u, 1'b1, 1'($urandom), d, 1'($urandom),
                 mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
            return;
         end
         if (j == rst_at) begin
            #2 rst[u] = 1'b0;
            #1;
            chk("rst_valid", u, vld[u], 1'b0);
            chk("rst_crc", u, crc[u], 1'b0);
            chk("rst_busy", u, bsy[u], 1'b0);
            chk("rst_done", u, cdn[u], 1'b0);
            chk("rst_err", u, cer[u], 1'b0);
            m_err[u] = 1'b0;
            step(u, 1'b0, 1'b1, d, 1'($urandom),
                 mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
            rst[u] = 1'b1;
            return;
         end
         if (m && (d != f[j])) mis = 1'b1;
         lst = (j == wid[u] - 1);
         if (lst && m) m_err[u] = mis;
         step(u, 1'b0, (j == pulse_at), d, 1'($urandom),
              mk(g, g & f[j], !lst, m & lst, m_err[u]));
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin : main
      bq_t msg;
      bq_t rx;
      logic [31:0] fr;
      logic [31:0] flip;
      int u;
      logic m;
      for (int k = 0; k < 2; k++) begin
         rst[k] = 1'b1;
         clr[k] = 1'b0;
         dat[k] = 1'b0;
         act[k] = 1'b0;
         mod[k] = 1'b0;
         m_err[k] = 1'b0;
      end
      #1;
      rst[0] = 1'b0;
      rst[1] = 1'b0;
      #1;
      for (int k = 0; k < 2; k++) begin
         chk("reset_valid", k, vld[k], 1'b0);
         chk("reset_crc", k, crc[k], 1'b0);
         chk("reset_busy", k, bsy[k], 1'b0);
         chk("reset_done", k, cdn[k], 1'b0);
         chk("reset_err", k, cer[k], 1'b0);
      end
      @(negedge CLK);
      @(negedge CLK);
      rst[0] = 1'b1;
      rst[1] = 1'b1;
      idle(0);

      // single zero bit -> 0x6C
      run_frame(0, MODE_GEN, mkq(64'h0, 1), mkq(64'h0, 32), -1, -1, -1);
      idle(0);
      #1;
      total++;
      if (cap8 !== 8'h6C) begin
         bad++;
         $display("FAIL gen_bit0 got=%h want=6c", cap8);
      end

      // single one bit -> 0xA8
      run_frame(0, MODE_GEN, mkq(64'h1, 1), mkq(64'h0, 32), -1, -1, -1);
      idle(0);
      #1;
      total++;
      if (cap8 !== 8'hA8) begin
         bad++;
         $display("FAIL gen_bit1 got=%h want=a8", cap8);
      end

      // CHECK with correct then corrupted received CRC
      run_frame(0, MODE_CHECK, mkq(64'h0, 1), mkq(64'h6C, 8), -1, -1, -1);
      idle(0);
      #1;
      chk("check_ok", 0, cer[0], 1'b0);
      run_frame(0, MODE_CHECK, mkq(64'h0, 1), mkq(64'h68, 8), -1, -1, -1);
      idle(0);
      idle(0);
      #1;
      chk("check_bad", 0, cer[0], 1'b1);

      // Clear mid-OUT, Clear with Active in IDLE, then a clean frame
      run_frame(0, MODE_GEN, mkq(64'h5A, 8), mkq(64'h0, 32), 4, -1, -1);
      idle(0);
      step(0, 1'b1, 1'b1, 1'b0, 1'b0, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      idle(0);
      run_frame(0, MODE_GEN, mkq(64'h0, 1), mkq(64'h0, 32), -1, -1, -1);
      idle(0);
      #1;
      total++;
      if (cap8 !== 8'h6C) begin
         bad++;
         $display("FAIL after_clear got=%h want=6c", cap8);
      end

      // Active pulse during OUT, then a back-to-back frame
      run_frame(0, MODE_GEN, mkq(64'h0, 1), mkq(64'h0, 32), -1, 3, -1);
      run_frame(0, MODE_GEN, mkq(64'h1, 1), mkq(64'h0, 32), -1, -1, -1);
      idle(0);
      #1;
      total++;
      if (cap8 !== 8'hA8) begin
         bad++;
         $display("FAIL back_to_back got=%h want=a8", cap8);
      end

      // randomized frames on both widths
      for (int it = 0; it < 30; it++) begin
         u = it % 2;
         m = 1'($urandom);
         if (u == 1) msg = mkq({$urandom, $urandom}, 64);
         else msg = mkq({$urandom, $urandom}, $urandom_range(1, 20));
         fr = crc_ref(u, msg) ^ xo[u];
         flip = ($urandom_range(0, 2) == 0) ?
                (32'h1 << $urandom_range(0, wid[u] - 1)) : 32'h0;
         rx = mkq(64'(fr ^ flip), wid[u]);
         run_frame(u, m, msg, rx, -1,
                   ($urandom_range(0, 3) == 0) ? $urandom_range(1, wid[u] - 1) : -1,
                   -1);
         for (int g = 0; g < $urandom_range(0, 2); g++) idle(u);
      end

      // async reset in the middle of a CRC-16 shift-out, then recovery
      run_frame(1, MODE_GEN, mkq({$urandom, $urandom}, 64), mkq(64'h0, 32),
                -1, -1, 5);
      idle(1);
      run_frame(1, MODE_GEN, mkq({$urandom, $urandom}, 64), mkq(64'h0, 32),
                -1, -1, -1);
      idle(1);
      idle(0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
